tooth_gap_sync: RTL and testbench
=================================

TOOTH_GAP_SYNC -- requirements
Module: tooth_gap_sync

Interface
REQ-001 Parameter WIDTH, default 16: width of the period counter and of the period outputs.
REQ-002 Parameter TCNT_WIDTH, default 8: width of the tooth counter.
REQ-003 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port ena  input  1  global enable; low holds all state and ignores cap.
REQ-006 Port cap  input  1  one-cycle tooth edge strobe (selected filtered edge).
REQ-007 Port teeth_last  input  TCNT_WIDTH  index of the last tooth before the gap (57 for a 60-2 wheel).
REQ-008 Port period0/period1/period2  output  WIDTH each  newest, previous and oldest latched tooth periods, in clk cycles.
REQ-009 Port tooth_cnt  output  TCNT_WIDTH  current tooth index; 0 is the first tooth after the gap.
REQ-010 Port sync  output  1  high while in SYNC.
REQ-011 Port gap  output  1  one-cycle pulse when a valid gap is accepted.
REQ-012 Port err  output  1  one-cycle pulse on a sync loss (early or missing gap).
REQ-013 Port ovf  output  1  level flag, set on period counter saturation.

Function
REQ-014 The period counter shall increment on each enabled cycle, load 1 on an enabled cap, and saturate at all-ones.
- A cap therefore latches the number of cycles since the previous cap.
REQ-015 On an enabled cap, the block shall shift the history: period2<=period1, period1<=period0, period0<=counter.
REQ-016 All outputs shall be registered and shall reflect a cap one cycle after cap is sampled high.
REQ-017 The gap criterion shall be new period > 2*period0, evaluated at WIDTH+1 bits with no wrap.
- period0 here is the value before the shift.
REQ-018 The FSM shall have states STOP, ARM, SEARCH, CONFIRM (macro only) and SYNC.
- STOP is the reset state.
REQ-019 STOP: a cap shall go to ARM; no period is latched.
REQ-020 ARM: a cap shall latch the first period and go to SEARCH.
REQ-021 SEARCH: a cap meeting the gap criterion shall go to SYNC, set tooth_cnt=0 and pulse gap.
- Otherwise the FSM stays in SEARCH.
REQ-022 SYNC, on a cap:
- Gap criterion met and tooth_cnt==teeth_last: set tooth_cnt=0, pulse gap, stay in SYNC.
- Gap criterion met and tooth_cnt!=teeth_last: pulse err, set tooth_cnt=0, go to SEARCH.
- No gap and tooth_cnt==teeth_last: pulse err, set tooth_cnt=0, go to SEARCH.
- Otherwise: tooth_cnt+1.
REQ-023 Counter saturation without a same-cycle cap shall, in ARM, SEARCH, CONFIRM or SYNC:
- set ovf and clear tooth_cnt;
- go to STOP;
- pulse err only if leaving SYNC.
REQ-024 Cap and saturation in the same cycle shall be processed as a cap with period = all-ones, and ovf shall not be set.
REQ-025 ovf shall clear on the next enabled cap.
REQ-026 gap and err shall never be high in the same cycle.
REQ-027 sync shall be high exactly when the FSM is in SYNC.

Reset
REQ-028 While rst is high on a clock edge, the block shall reset to:
- FSM in STOP;
- counter=0;
- period0..2=0;
- tooth_cnt=0;
- sync, gap, err and ovf all 0.
REQ-029 rst shall take priority over ena and cap, including in mid-revolution SYNC; no err pulse shall be generated by reset.

Configuration
REQ-030 Macro TOOTH_GAP_CONFIRM_EN shall control gap confirmation on acquisition.
REQ-031 With TOOTH_GAP_CONFIRM_EN defined:
- SEARCH shall go to CONFIRM on a gap candidate.
- CONFIRM, on the next cap: if 2*new period < period0 (the gap), go to SYNC with tooth_cnt=0 and pulse gap; otherwise go to SEARCH.
- Resync in SYNC is unchanged.
REQ-032 Without the macro, the CONFIRM state shall not exist and REQ-021 shall apply directly.

Verification
REQ-033 60-2 wheel: teeth_last=57, 100-cycle teeth, 300-cycle gap, three revolutions.
- gap pulses once per revolution.
- sync stays high.
- tooth_cnt counts 0..57.
- err stays 0.
REQ-034 Early gap: inject a 300-cycle period at tooth_cnt=30.
- err pulses.
- sync drops.
- tooth_cnt=0.
- Next true gap reacquires SYNC.
REQ-035 Missing gap: 100-cycle period at tooth_cnt=57.
- err pulses.
- FSM goes to SEARCH.
REQ-036 Stall: WIDTH=8, no cap for 300 cycles while in SYNC.
- Saturation at 255 sets ovf, pulses err and enters STOP.
- The next cap clears ovf and enters ARM.
REQ-037 Reset: rst in mid-SYNC at tooth_cnt=20.
- Next cycle: all outputs 0, STOP, no err.
- Hold: ena low for 50 cycles with caps present; no state change.
REQ-038 With TOOTH_GAP_CONFIRM_EN: a 300-cycle gap followed by a 290-cycle period returns to SEARCH without a gap pulse.
- A gap followed by a 100-cycle period yields sync with tooth_cnt=0.

Source files
------------

// File: rtl/tooth_gap_sync.sv
// Crank tooth/gap synchroniser: measures tooth periods, detects the missing-tooth gap and tracks the tooth index.
// Optional macro TOOTH_GAP_CONFIRM_EN adds a one-tooth confirmation step before acquiring sync.
module tooth_gap_sync #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cap,
  input  logic [TCNT_WIDTH-1:0] teeth_last,
  output logic [WIDTH-1:0]      period0,
  output logic [WIDTH-1:0]      period1,
  output logic [WIDTH-1:0]      period2,
  output logic [TCNT_WIDTH-1:0] tooth_cnt,
  output logic                  sync,
  output logic                  gap,
  output logic                  err,
  output logic                  ovf
);

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SEARCH  = 3'd2,
`ifdef TOOTH_GAP_CONFIRM_EN
    ST_CONFIRM = 3'd3,
`endif
    ST_SYNC    = 3'd4
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [WIDTH-1:0]        cnt_q;
  logic                    sat_c;
  logic                    gap_crit_c;
  logic                    shift_c;
  logic [TCNT_WIDTH-1:0]   tcnt_d;
  logic                    gap_d;
  logic                    err_d;
  logic                    ovf_d;

  // Comparisons are one bit wider so doubling period0 never wraps.
  assign sat_c      = (cnt_q == {WIDTH{1'b1}});
  assign gap_crit_c = {1'b0, cnt_q} > {period0, 1'b0};
`ifdef TOOTH_GAP_CONFIRM_EN
  logic confirm_c;
  assign confirm_c  = {cnt_q, 1'b0} < {1'b0, period0};
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tooth_cnt;
    gap_d   = 1'b0;
    err_d   = 1'b0;
    ovf_d   = ovf;
    shift_c = 1'b0;
    if (ena && cap) begin
      ovf_d   = 1'b0;
      shift_c = (state_q != ST_STOP);
      case (state_q)
        ST_STOP:   state_d = ST_ARM;
        ST_ARM:    state_d = ST_SEARCH;
        ST_SEARCH: begin
          if (gap_crit_c) begin
`ifdef TOOTH_GAP_CONFIRM_EN
            state_d = ST_CONFIRM;
`else
            state_d = ST_SYNC;
            tcnt_d  = '0;
            gap_d   = 1'b1;
`endif
          end
        end
`ifdef TOOTH_GAP_CONFIRM_EN
        ST_CONFIRM: begin
          if (confirm_c) begin
            state_d = ST_SYNC;
            tcnt_d  = '0;
            gap_d   = 1'b1;
          end else begin
            state_d = ST_SEARCH;
          end
        end
`endif
        ST_SYNC: begin
          if (gap_crit_c && (tooth_cnt == teeth_last)) begin
            tcnt_d = '0;
            gap_d  = 1'b1;
          end else if (gap_crit_c || (tooth_cnt == teeth_last)) begin
            state_d = ST_SEARCH;
            tcnt_d  = '0;
            err_d   = 1'b1;
          end else begin
            tcnt_d = tooth_cnt + TCNT_WIDTH'(1);
          end
        end
        default: state_d = ST_STOP;
      endcase
    end else if (ena && sat_c && (state_q != ST_STOP)) begin
      // Stalled wheel: drop to STOP and flag the overflow.
      state_d = ST_STOP;
      tcnt_d  = '0;
      ovf_d   = 1'b1;
      err_d   = (state_q == ST_SYNC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  // Period counter, period history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      period0   <= '0;
      period1   <= '0;
      period2   <= '0;
      tooth_cnt <= '0;
      sync      <= 1'b0;
      gap       <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sync      <= (state_d == ST_SYNC);
      gap       <= gap_d;
      err       <= err_d;
      ovf       <= ovf_d;
      tooth_cnt <= tcnt_d;
      if (ena) begin
        if (cap)         cnt_q <= WIDTH'(1);
        else if (!sat_c) cnt_q <= cnt_q + WIDTH'(1);
      end
      if (shift_c) begin
        period2 <= period1;
        period1 <= period0;
        period0 <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_tooth_gap_sync.sv
// Self-checking bench for tooth_gap_sync: 16-bit and 8-bit instances against a cycle-level reference model.
module tb_tooth_gap_sync;

  localparam int M_STOP = 0, M_ARM = 1, M_SEARCH = 2, M_CONFIRM = 3, M_SYNC = 4;
`ifdef TOOTH_GAP_CONFIRM_EN
  localparam bit CONFIRM = 1'b1;
`else
  localparam bit CONFIRM = 1'b0;
`endif

  typedef struct {
    int     mode;
    longint cnt;
    longint p0;
    longint p1;
    longint p2;
    int     tc;
    bit     gap;
    bit     err;
    bit     ovf;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst, ena, cap;
  logic [7:0] teeth_last;

  logic [15:0] p0_a, p1_a, p2_a;
  logic [7:0]  tc_a;
  logic        sync_a, gap_a, err_a, ovf_a;
  logic [7:0]  p0_b, p1_b, p2_b;
  logic [7:0]  tc_b;
  logic        sync_b, gap_b, err_b, ovf_b;

  tooth_gap_sync dut (
    .clk(clk), .rst(rst), .ena(ena), .cap(cap), .teeth_last(teeth_last),
    .period0(p0_a), .period1(p1_a), .period2(p2_a), .tooth_cnt(tc_a),
    .sync(sync_a), .gap(gap_a), .err(err_a), .ovf(ovf_a)
  );

  tooth_gap_sync #(.WIDTH(8), .TCNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .cap(cap), .teeth_last(teeth_last),
    .period0(p0_b), .period1(p1_b), .period2(p2_b), .tooth_cnt(tc_b),
    .sync(sync_b), .gap(gap_b), .err(err_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  mdl_t ma, mb;
  bit   rand_ena = 1'b0;
  int   n_gap_a = 0, n_err_a = 0, n_err_b = 0;
  bit   sync_dropped = 1'b0;
  int   tc_max = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, straight from the rules on caps, gaps and stalls.
  function automatic mdl_t mdl_step(input mdl_t s, input longint maxv, input bit r,
                                    input bit e, input bit c, input int last);
    mdl_t   n;
    longint per;
    bit     big;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.gap = 1'b0;
    n.err = 1'b0;
    if (!e) return n;
    if (c) begin
      per   = s.cnt;
      n.ovf = 1'b0;
      n.cnt = 1;
      if (s.mode == M_STOP) begin
        n.mode = M_ARM;
      end else begin
        big  = per > 2 * s.p0;
        n.p2 = s.p1;
        n.p1 = s.p0;
        n.p0 = per;
        if (s.mode == M_ARM) begin
          n.mode = M_SEARCH;
        end else if (s.mode == M_SEARCH) begin
          if (big && CONFIRM) n.mode = M_CONFIRM;
          else if (big) begin n.mode = M_SYNC; n.tc = 0; n.gap = 1'b1; end
        end else if (s.mode == M_CONFIRM) begin
          if (2 * per < s.p0) begin n.mode = M_SYNC; n.tc = 0; n.gap = 1'b1; end
          else n.mode = M_SEARCH;
        end else begin
          if (big && s.tc == last) begin n.tc = 0; n.gap = 1'b1; end
          else if (big || s.tc == last) begin n.mode = M_SEARCH; n.tc = 0; n.err = 1'b1; end
          else n.tc = (s.tc + 1) % 256;
        end
      end
    end else if (s.cnt == maxv) begin
      if (s.mode != M_STOP) begin
        n.err  = (s.mode == M_SYNC);
        n.mode = M_STOP;
        n.tc   = 0;
        n.ovf  = 1'b1;
      end
    end else begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  task automatic cmp(input string who, input mdl_t m, input logic [63:0] p0, input logic [63:0] p1,
                     input logic [63:0] p2, input logic [63:0] tc, input logic sy, input logic g,
                     input logic e, input logic o);
    check({who, ".period0"}, p0, 64'(m.p0));
    check({who, ".period1"}, p1, 64'(m.p1));
    check({who, ".period2"}, p2, 64'(m.p2));
    check({who, ".tooth_cnt"}, tc, 64'(m.tc));
    check({who, ".sync"}, 64'(sy), 64'(m.mode == M_SYNC));
    check({who, ".gap"}, 64'(g), 64'(m.gap));
    check({who, ".err"}, 64'(e), 64'(m.err));
    check({who, ".ovf"}, 64'(o), 64'(m.ovf));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare shortly after it.
  task automatic step(input bit c);
    cap = c;
    if (rand_ena) ena = ($urandom_range(0, 9) != 0);
    @(posedge clk);
    ma = mdl_step(ma, 65535, rst, ena, cap, int'(teeth_last));
    mb = mdl_step(mb, 255, rst, ena, cap, int'(teeth_last));
    #1;
    cmp("w16", ma, 64'(p0_a), 64'(p1_a), 64'(p2_a), 64'(tc_a), sync_a, gap_a, err_a, ovf_a);
    cmp("w8", mb, 64'(p0_b), 64'(p1_b), 64'(p2_b), 64'(tc_b), sync_b, gap_b, err_b, ovf_b);
    n_gap_a += int'(gap_a);
    n_err_a += int'(err_a);
    n_err_b += int'(err_b);
    if (sync_a !== 1'b1) sync_dropped = 1'b1;
    if (int'(tc_a) > tc_max) tc_max = int'(tc_a);
  endtask

  // Period P between caps: P-1 quiet cycles then the cap cycle.
  task automatic tooth(input int p);
    for (int i = 0; i < p - 1; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic gap_acq(input int tp);
    tooth(3 * tp);
    if (CONFIRM) tooth(tp);
  endtask

  task automatic acquire(input int tp);
    tooth(tp);
    tooth(tp);
    gap_acq(tp);
  endtask

  task automatic rev(input bit jit);
    for (int k = 0; k < 57; k++) tooth(jit ? 95 + int'($urandom_range(0, 10)) : 100);
    tooth(jit ? 290 + int'($urandom_range(0, 20)) : 300);
  endtask

  int g0, e0, eb0;

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1'b1; ena = 1'b1; cap = 1'b0; teeth_last = 8'd57;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
    check("reset.sync", 64'(sync_a), 64'd0);
    check("reset.tooth_cnt", 64'(tc_a), 64'd0);

    // 60-2 wheel: three revolutions after acquisition, last two jittered.
    acquire(100);
    check("acq.sync", 64'(sync_a), 64'd1);
    check("acq.tooth_cnt", 64'(tc_a), 64'd0);
    g0 = n_gap_a; e0 = n_err_a; sync_dropped = 1'b0; tc_max = 0;
    rev(1'b0);
    rev(1'b1);
    rev(1'b1);
    check("wheel.gaps", 64'(n_gap_a - g0), 64'd3);
    check("wheel.errs", 64'(n_err_a - e0), 64'd0);
    check("wheel.sync_held", 64'(sync_dropped), 64'd0);
    check("wheel.tc_max", 64'(tc_max), 64'd57);

    // Early gap at tooth 30, then reacquire on the true gap.
    for (int k = 0; k < 30; k++) tooth(100);
    check("early.tc30", 64'(tc_a), 64'd30);
    e0 = n_err_a;
    tooth(300);
    check("early.err", 64'(n_err_a - e0), 64'd1);
    check("early.sync", 64'(sync_a), 64'd0);
    check("early.tooth_cnt", 64'(tc_a), 64'd0);
    for (int k = 0; k < 26; k++) tooth(100);
    gap_acq(100);
    check("reacq.sync", 64'(sync_a), 64'd1);
    check("reacq.tooth_cnt", 64'(tc_a), 64'd0);

    // Missing gap: a normal tooth where the gap should be.
    for (int k = 0; k < 57; k++) tooth(100);
    e0 = n_err_a;
    tooth(100);
    check("missing.err", 64'(n_err_a - e0), 64'd1);
    check("missing.sync", 64'(sync_a), 64'd0);

    if (CONFIRM) begin
      g0 = n_gap_a;
      tooth(300);
      tooth(290);
      check("confirm.reject_gap", 64'(n_gap_a - g0), 64'd0);
      check("confirm.reject_sync", 64'(sync_a), 64'd0);
      tooth(100);
      tooth(300);
      tooth(100);
      check("confirm.accept_sync", 64'(sync_a), 64'd1);
      check("confirm.accept_tc", 64'(tc_a), 64'd0);
    end

    // Reset mid-SYNC at tooth 20, then hold with ena low.
    tooth(100);
    gap_acq(100);
    for (int k = 0; k < 20; k++) tooth(100);
    check("rst.tc20", 64'(tc_a), 64'd20);
    e0 = n_err_a;
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("rst.sync", 64'(sync_a), 64'd0);
    check("rst.period0", 64'(p0_a), 64'd0);
    check("rst.err", 64'(n_err_a - e0), 64'd0);
    ena = 1'b0;
    for (int k = 0; k < 50; k++) step(1'($urandom_range(0, 3) == 0));
    check("hold.period0", 64'(p0_a), 64'd0);
    check("hold.tooth_cnt", 64'(tc_a), 64'd0);
    ena = 1'b1;

    // Stall on the 8-bit instance while in SYNC.
    acquire(40);
    for (int k = 0; k < 5; k++) tooth(40);
    check("stall.pre_sync", 64'(sync_b), 64'd1);
    eb0 = n_err_b;
    for (int k = 0; k < 300; k++) step(1'b0);
    check("stall.ovf", 64'(ovf_b), 64'd1);
    check("stall.err", 64'(n_err_b - eb0), 64'd1);
    check("stall.sync", 64'(sync_b), 64'd0);
    check("stall.w16_ovf", 64'(ovf_a), 64'd0);
    step(1'b1);
    check("stall.ovf_clear", 64'(ovf_b), 64'd0);

    // Randomised wheel with short revolutions, random enable and occasional reset.
    teeth_last = 8'd5;
    rand_ena = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int p;
      p = int'($urandom_range(20, 40));
      if ($urandom_range(0, 5) == 0) p = 3 * p;
      if ($urandom_range(0, 40) == 0) p = 300;
      rst = ($urandom_range(0, 60) == 0);
      tooth(p);
      rst = 1'b0;
    end
    rand_ena = 1'b0;
    ena = 1'b1;
    step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
